// File: rtl/dec_scan.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : dec_scan                                                   |
// | Brief    : Registered AW-to-2^AW one-hot decoder with a direct mode   |
// |            and a prescaled scan mode for multiplexed select lines.    |
// | Options  : DEC_SCAN_ACTLOW_EN - drive y active-low (idle all ones).   |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module dec_scan #(
  parameter int AW       = 4,
  parameter int PRESCALE = 4,
  parameter int LAST     = (1 << AW) - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic [AW-1:0]     addr,
  input  logic              load,
  output logic [2**AW-1:0]  y,
  output logic [AW-1:0]     idx,
  output logic              wrap
);

  localparam int          N      = 2 ** AW;
  localparam int          CW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] c_pmax = CW'(PRESCALE - 1);
  localparam logic [AW-1:0] c_last = AW'(LAST);
  localparam logic [N-1:0]  c_one  = {{(N-1){1'b0}}, 1'b1};

`ifdef DEC_SCAN_ACTLOW_EN
  localparam logic [N-1:0] c_y_off = {N{1'b1}};
  localparam logic [N-1:0] c_y_pol = {N{1'b1}};
`else
  localparam logic [N-1:0] c_y_off = {N{1'b0}};
  localparam logic [N-1:0] c_y_pol = {N{1'b0}};
`endif

  logic [AW-1:0] r_idx;
  logic [CW-1:0] r_cnt;
  logic          r_wrap;
  logic [N-1:0]  r_y;

  logic [AW-1:0] w_idx_nx;
  logic [CW-1:0] w_cnt_nx;
  logic          w_wrap_nx;
  logic [N-1:0]  w_y_nx;

  always_comb begin
    w_idx_nx  = r_idx;
    w_cnt_nx  = r_cnt;
    w_wrap_nx = 1'b0;
    if (en) begin
      if (!mode) begin
        w_idx_nx = addr;
        w_cnt_nx = '0;
      end else if (load) begin
        w_idx_nx = (addr > c_last) ? c_last : addr;
        w_cnt_nx = '0;
      end else if (r_cnt == c_pmax) begin
        // An index left above LAST by direct mode also wraps on its first step.
        w_cnt_nx  = '0;
        w_wrap_nx = (r_idx >= c_last);
        w_idx_nx  = (r_idx >= c_last) ? '0 : r_idx + 1'b1;
      end else begin
        w_cnt_nx = r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_y_nx = c_y_off;
    if (en) begin
      w_y_nx = (c_one << w_idx_nx) ^ c_y_pol;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_cnt  <= '0;
      r_wrap <= 1'b0;
      r_y    <= c_y_off;
    end else begin
      r_idx  <= w_idx_nx;
      r_cnt  <= w_cnt_nx;
      r_wrap <= w_wrap_nx;
      r_y    <= w_y_nx;
    end
  end

  assign y    = r_y;
  assign idx  = r_idx;
  assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_dec_scan.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_dec_scan                                                |
// | Brief    : Directed self-checking bench for dec_scan.                 |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_dec_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        a_en = 1'b0, a_mode = 1'b0, a_load = 1'b0;
  logic [3:0]  a_addr = 4'd0;
  logic [15:0] a_y;
  logic [3:0]  a_idx;
  logic        a_wrap;

  logic        b_en = 1'b0, b_mode = 1'b0, b_load = 1'b0;
  logic [3:0]  b_addr = 4'd0;
  logic [15:0] b_y;
  logic [3:0]  b_idx;
  logic        b_wrap;

  logic        c_en = 1'b0, c_mode = 1'b0;
  logic        c_load = 1'b0;
  logic [3:0]  c_addr = 4'd0;
  logic [15:0] c_y;
  logic [3:0]  c_idx;
  logic        c_wrap;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dec_scan #(.AW(4), .PRESCALE(4), .LAST(15)) u_dut_a (
    .clk(clk), .rst(rst), .en(a_en), .mode(a_mode), .addr(a_addr),
    .load(a_load), .y(a_y), .idx(a_idx), .wrap(a_wrap)
  );

  dec_scan #(.AW(4), .PRESCALE(4), .LAST(10)) u_dut_b (
    .clk(clk), .rst(rst), .en(b_en), .mode(b_mode), .addr(b_addr),
    .load(b_load), .y(b_y), .idx(b_idx), .wrap(b_wrap)
  );

  dec_scan #(.AW(4), .PRESCALE(1), .LAST(2)) u_dut_c (
    .clk(clk), .rst(rst), .en(c_en), .mode(c_mode), .addr(c_addr),
    .load(c_load), .y(c_y), .idx(c_idx), .wrap(c_wrap)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected y for a given enable and index, honouring the output polarity.
  function automatic logic [15:0] ey(input logic e, input int i);
    logic [15:0] v;
    v = e ? (16'd1 << i) : 16'd0;
`ifdef DEC_SCAN_ACTLOW_EN
    v = ~v;
`endif
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #12;
    chk("reset_y",    a_y,    ey(1'b0, 0));
    chk("reset_idx",  a_idx,  4'd0);
    chk("reset_wrap", a_wrap, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Direct decode
    a_en = 1'b1; a_mode = 1'b0; a_addr = 4'd9;
    tick(1);
    chk("direct9_y",   a_y,   ey(1'b1, 9));
    chk("direct9_idx", a_idx, 4'd9);
    a_addr = 4'd0; a_load = 1'b1;
    tick(1);
    chk("direct0_y",   a_y,   ey(1'b1, 0));
    chk("direct0_idx", a_idx, 4'd0);
    a_load = 1'b0;

    // Scan: one step every 4 clocks, full lap with a single wrap pulse
    a_mode = 1'b1;
    tick(3);
    chk("scan_hold0", a_idx, 4'd0);
    tick(1);
    chk("scan_step1_idx", a_idx, 4'd1);
    chk("scan_step1_y",   a_y,   ey(1'b1, 1));
    for (int i = 2; i <= 15; i++) begin
      tick(4);
      chk("scan_lap_idx", a_idx, i);
      chk("scan_lap_y",   a_y,   ey(1'b1, i));
      chk("scan_lap_nowrap", a_wrap, 1'b0);
    end
    tick(3);
    chk("scan_15_hold",   a_idx,  4'd15);
    chk("scan_15_nowrap", a_wrap, 1'b0);
    tick(1);
    chk("scan_wrap_idx",  a_idx,  4'd0);
    chk("scan_wrap_pulse", a_wrap, 1'b1);
    chk("scan_wrap_y",    a_y,    ey(1'b1, 0));
    tick(1);
    chk("scan_wrap_once", a_wrap, 1'b0);

    // Load mid-count restarts the prescaler (state: idx=0, cnt=1)
    tick(1);
    a_load = 1'b1; a_addr = 4'd12;
    tick(1);
    a_load = 1'b0;
    chk("load12_idx", a_idx, 4'd12);
    chk("load12_y",   a_y,   ey(1'b1, 12));
    tick(3);
    chk("load12_hold", a_idx, 4'd12);
    tick(1);
    chk("load12_step", a_idx, 4'd13);

    // en=0 for 3 clocks at idx=5, cnt=2
    a_load = 1'b1; a_addr = 4'd5;
    tick(1);
    a_load = 1'b0;
    tick(2);
    a_en = 1'b0; a_load = 1'b1; a_addr = 4'd1;
    tick(1);
    chk("en0_y",    a_y,   ey(1'b0, 0));
    chk("en0_idx",  a_idx, 4'd5);
    tick(2);
    chk("en0_hold", a_idx, 4'd5);
    a_en = 1'b1; a_load = 1'b0;
    tick(1);
    chk("en1_resume_idx", a_idx, 4'd5);
    chk("en1_resume_y",   a_y,   ey(1'b1, 5));
    tick(1);
    chk("en1_step6", a_idx, 4'd6);

    // Leaving scan mid-count takes effect at once
    a_mode = 1'b0; a_addr = 4'd3;
    tick(1);
    chk("leave_scan_idx", a_idx, 4'd3);
    chk("leave_scan_y",   a_y,   ey(1'b1, 3));

    // Asynchronous reset mid-scan at idx=7
    a_mode = 1'b1; a_load = 1'b1; a_addr = 4'd7;
    tick(1);
    a_load = 1'b0;
    tick(1);
    chk("pre_rst_idx", a_idx, 4'd7);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_y",    a_y,    ey(1'b0, 0));
    chk("async_rst_idx",  a_idx,  4'd0);
    chk("async_rst_wrap", a_wrap, 1'b0);
    @(negedge clk);
    a_en = 1'b0;
    rst = 1'b0;

    // LAST=10: load clamps, and an index above LAST wraps on its first step
    b_en = 1'b1; b_mode = 1'b1; b_load = 1'b1; b_addr = 4'd14;
    tick(1);
    b_load = 1'b0;
    chk("clamp_idx", b_idx, 4'd10);
    chk("clamp_y",   b_y,   ey(1'b1, 10));
    tick(4);
    chk("last10_wrap_idx", b_idx,  4'd0);
    chk("last10_wrap",     b_wrap, 1'b1);
    b_mode = 1'b0; b_addr = 4'd13;
    tick(1);
    chk("above_last_idx", b_idx, 4'd13);
    b_mode = 1'b1;
    tick(3);
    chk("above_last_hold", b_idx, 4'd13);
    tick(1);
    chk("above_last_wrap_idx", b_idx,  4'd0);
    chk("above_last_wrap",     b_wrap, 1'b1);

    // PRESCALE=1, LAST=2: step every edge
    c_en = 1'b1; c_mode = 1'b1;
    tick(1);
    chk("ps1_idx1", c_idx, 4'd1);
    tick(1);
    chk("ps1_idx2", c_idx, 4'd2);
    chk("ps1_nowrap", c_wrap, 1'b0);
    tick(1);
    chk("ps1_idx0",  c_idx,  4'd0);
    chk("ps1_wrap",  c_wrap, 1'b1);
    chk("ps1_y",     c_y,    ey(1'b1, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/dec_scan.md
Name: dec_scan

Overview:
- Parametrised, registered AW-to-2^AW one-hot decoder.
- Successor to the combinational 4-to-16 decoder.
- Two modes:
  - Direct: decodes the addr input.
  - Scan: an internal prescaled counter steps the active output through 0..LAST and wraps.
- Used as a digit/row select driver for multiplexed displays and banked enables.

Parameters:
- AW, 4, address width; output width is 2^AW.
- PRESCALE, 4, clock cycles per scan step (legal range 1..65535).
- LAST, 2^AW-1, highest index visited in scan mode (legal range 0..2^AW-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  output enable; when 0, all outputs go inactive.
- mode  in  1  0 = direct decode, 1 = scan.
- addr  in  AW  direct-mode address; also the scan-mode load value.
- load  in  1  scan mode only: jump to addr on this cycle.
- y  out  2^AW  registered one-hot select.
- idx  out  AW  registered current index.
- wrap  out  1  one-cycle pulse when the scan index steps from LAST to 0.

Behaviour:
- Reset (asynchronous, rst=1): y=0, idx=0, wrap=0, prescale count cnt=0; held while rst=1.
- After rst deasserts: first update happens on the first rising clk edge.
- All outputs are registered. Latency from input to y/idx is 1 clock.
- Invariant: y == (en_q ? 1<<idx : 0), where en_q is en registered.
- en=0:
  - next y=0.
  - idx and cnt hold.
  - load is ignored.
  - wrap=0.
- Direct mode (mode=1'b0, en=1):
  - Each edge: idx<=addr, y<=1<<addr, cnt<=0, wrap<=0.
  - load has no effect in direct mode.
- Scan mode (mode=1'b1, en=1), cnt counts 0..PRESCALE-1:
  - load=1 has priority over stepping:
    - idx<=min(addr, LAST), cnt<=0, wrap<=0.
    - addr>LAST clamps to LAST.
  - Otherwise, if cnt==PRESCALE-1:
    - cnt<=0.
    - idx<=(idx==LAST) ? 0 : idx+1.
    - wrap<=(idx==LAST).
  - Otherwise: cnt<=cnt+1, idx holds, wrap<=0.
  - y<=1<<(next idx).
- PRESCALE=1: index steps on every edge.
- LAST=0: idx stays 0; wrap pulses every PRESCALE cycles.
- Entering scan mode from direct mode: scanning starts at the current idx, with cnt=0 (guaranteed by direct-mode clearing).
  - If current idx>LAST, the first step goes to 0 with wrap=1.
- Leaving scan mode: direct decode takes effect on the next edge, mid-count.
- en toggled 0->1 in scan mode: resumes from the held idx and cnt, with no step skipped.
- rst mid-scan: immediately returns to idx=0, cnt=0, y=0. No wrap is emitted.
- cnt width: ceil(log2(PRESCALE)), minimum 1 bit.
- No arithmetic overflow beyond the defined wrap.

Optional Feature:
- Macro DEC_SCAN_ACTLOW_EN.
- Defined:
  - y is driven active-low: one-hot-zero when enabled, all ones when en_q=0 or in reset.
  - The reset value of y becomes all ones.
- Undefined:
  - y is active-high as above; reset value all zeros.
- idx and wrap are unaffected either way.

Test Plan (AW=4, PRESCALE=4, LAST=15, macro undefined unless stated):
- Reset, then en=1, mode=0, addr=9 -> one edge later y=16'h0200, idx=9; addr=0 -> y=16'h0001 next edge.
- mode=1 from idx=0, load=0 -> idx increments every 4 clocks (0,1,2,...); y follows one-hot; after idx=15 for 4 clocks, idx=0 with wrap=1 for exactly 1 cycle.
- Scan with load=1, addr=12 in the middle of a prescale count -> next edge idx=12, y=16'h1000, cnt restarts so the next step to 13 occurs 4 clocks later; rebuild with LAST=10 and load addr=14 -> idx=10.
- en=0 for 3 clocks during scan at idx=5, cnt=2 -> y=0, idx stays 5; after en=1 the step to 6 occurs 2 clocks later.
- Assert rst asynchronously between edges during scan at idx=7 -> y=0, idx=0, wrap=0 immediately, without waiting for an edge.
- With DEC_SCAN_ACTLOW_EN defined: reset -> y=16'hFFFF; direct addr=3 -> y=16'hFFF7.
